// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Packet-level round-robin arbiter that shares one byte-wide framer among
//   NUM_CH AXI4-Stream byte sources. A source is granted for a whole packet
//   and keeps the grant until its tlast byte. If ID_ENABLE is set, every
//   packet is preceded by a channel-ID byte (ID_BASE + channel index) so the
//   far-end deframer can demultiplex the stream.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_tvalid/s_tready    per-channel handshake (NUM_CH bits)
//   s_tdata              per-channel byte, channel i at [8i+7:8i]
//   s_tlast              per-channel end of packet
//   m_tvalid/m_tready    handshake toward the framer target interface
//   m_tdata, m_tlast     registered output byte and end-of-packet flag
//   grant                index of the current / most recently granted channel
//   busy                 high while a packet is in progress
module axis_frame_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter bit          ID_ENABLE = 1'b1,
    parameter logic [7:0]  ID_BASE   = 8'h00,
    localparam int unsigned GW       = $clog2(NUM_CH)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NUM_CH-1:0]   s_tvalid,
    output logic [NUM_CH-1:0]   s_tready,
    input  logic [8*NUM_CH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]   s_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [7:0]          m_tdata,
    output logic                m_tlast,
    output logic [GW-1:0]       grant,
    output logic                busy
);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("axis_frame_arbiter: NUM_CH must be in 2..16");
    end

    // ID bytes are not escaped by the framer, so they must stay below the
    // framing byte values.
    if ((32'(ID_BASE) + NUM_CH - 1) >= 32'h7D) begin : g_bad_id_base
        $error("axis_frame_arbiter: ID_BASE + NUM_CH - 1 must be below 8'h7D");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND_ID,
        STREAM
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [GW-1:0]  grant_d;
    logic [GW-1:0]  cand;
    logic [GW-1:0]  pick;
    logic           found;
    logic           out_free;
    logic           load;
    logic [7:0]     load_data;
    logic           load_last;

    assign out_free = !m_tvalid || m_tready;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        s_tready  = '0;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        cand      = '0;
        pick      = grant;
        found     = 1'b0;

        // Round-robin search starting one past the last grant, wrapping.
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = GW'((32'(grant) + i) % NUM_CH);
            if (!found && s_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        unique case (state_q)
            IDLE: begin
                // May run while the previous packet's last byte still drains.
                if (found) begin
                    grant_d = pick;
                    state_d = ID_ENABLE ? SEND_ID : STREAM;
                end
            end
            SEND_ID: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = ID_BASE + 8'(grant);
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                s_tready[grant] = out_free;
                if (s_tvalid[grant] && out_free) begin
                    load      = 1'b1;
                    load_data = s_tdata[{grant, 3'b000} +: 8];
                    load_last = s_tlast[grant];
                    if (s_tlast[grant]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant    <= GW'(NUM_CH - 1);
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            if (load) begin
                m_tvalid <= 1'b1;
                m_tdata  <= load_data;
                m_tlast  <= load_last;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
`timescale 1ns/1ps
module tb_axis_frame_arbiter;

    localparam int NCH = 4;
    localparam int GW  = 2;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;

    logic [NCH-1:0]     s_tvalid, s_tready, s_tlast;
    logic [8*NCH-1:0]   s_tdata;
    logic               m_tvalid, m_tready, m_tlast;
    logic [7:0]         m_tdata;
    logic [GW-1:0]      grant;
    logic               busy;

    logic [NCH-1:0]     z_tvalid, z_tready, z_tlast;
    logic [8*NCH-1:0]   z_tdata;
    logic               zm_tvalid, zm_tready, zm_tlast;
    logic [7:0]         zm_tdata;
    logic [GW-1:0]      z_grant;
    logic               z_busy;

    always #5 aclk = ~aclk;

    axis_frame_arbiter #(.NUM_CH(NCH), .ID_ENABLE(1'b1), .ID_BASE(8'h00)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .grant(grant), .busy(busy)
    );

    axis_frame_arbiter #(.NUM_CH(NCH), .ID_ENABLE(1'b0), .ID_BASE(8'h00)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(z_tvalid), .s_tready(z_tready), .s_tdata(z_tdata), .s_tlast(z_tlast),
        .m_tvalid(zm_tvalid), .m_tready(zm_tready), .m_tdata(zm_tdata), .m_tlast(zm_tlast),
        .grant(z_grant), .busy(z_busy)
    );

    typedef struct packed { logic [7:0] d; logic l; } sbeat_t;
    typedef struct packed { logic [7:0] d; logic l; logic id; logic [GW-1:0] ch; } obeat_t;

    // Reference model: per-source byte queues, expected output stream, and
    // the packet order in which sources must be served.
    sbeat_t       srcq [NCH][$];
    obeat_t       expq [$];
    int           ordq [$];
    sbeat_t       zq [$];
    sbeat_t       expq0 [$];
    int unsigned  consumed [NCH];
    bit           mid [NCH];
    int           cnt [NCH];
    int           mlast;
    logic [7:0]   pkt [$];
    logic [7:0]   beat_log [$];
    logic         last_log [$];
    logic [7:0]   id_log [$];
    int           zbeats;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 0;
    bit  mon0_en = 0;
    bit  rdy_rand = 0;
    bit  gaps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the packet held in pkt on channel ch and extend the expected stream.
    task automatic add_packet(input int ch);
        obeat_t o;
        sbeat_t s;
        o.d = 8'(ch); o.l = 1'b0; o.id = 1'b1; o.ch = GW'(ch);
        expq.push_back(o);
        foreach (pkt[k]) begin
            s.d = pkt[k]; s.l = (k == pkt.size() - 1);
            srcq[ch].push_back(s);
            o.d = s.d; o.l = s.l; o.id = 1'b0; o.ch = GW'(ch);
            expq.push_back(o);
        end
        ordq.push_back(ch);
        mlast = ch;
    endtask

    // All sources with pending packets are valid at every arbitration point,
    // so the service order is plain round robin over channels with work left.
    task automatic rr_load(input int fixed_len);
        int left;
        int ch;
        int len;
        bit picked;
        left = 0;
        for (int c = 0; c < NCH; c++) left += cnt[c];
        while (left > 0) begin
            picked = 0;
            for (int i = 1; i <= NCH; i++) begin
                ch = (mlast + i) % NCH;
                if (!picked && cnt[ch] > 0) begin
                    picked = 1;
                    len = (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
                    pkt.delete();
                    repeat (len) pkt.push_back(8'($urandom));
                    add_packet(ch);
                    cnt[ch]--;
                    left--;
                end
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((expq.size() > 0 || ordq.size() > 0) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (expq.size() > 0 || ordq.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats outstanding, expected 0 after %0d cycles", name, expq.size(), budget);
            expq.delete();
            ordq.delete();
            for (int c = 0; c < NCH; c++) srcq[c].delete();
        end
        @(negedge aclk);
        #1;
    endtask

    task automatic wait_consumed(input int ch, input int unsigned target, input string name);
        int n;
        n = 0;
        while (consumed[ch] < target && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (consumed[ch] < target) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d bytes consumed, expected %0d", name, consumed[ch], target);
        end
    endtask

    // Source driver for the ID-enabled instance.
    initial begin
        bit hs [NCH];
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1;
        for (int c = 0; c < NCH; c++) begin consumed[c] = 0; mid[c] = 0; end
        forever begin
            @(negedge aclk);
            for (int c = 0; c < NCH; c++) hs[c] = s_tvalid[c] && s_tready[c];
            @(posedge aclk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (hs[c] && srcq[c].size() > 0) begin
                    mid[c] = !srcq[c][0].l;
                    void'(srcq[c].pop_front());
                    consumed[c]++;
                end
                if (srcq[c].size() > 0) begin
                    s_tvalid[c] = mid[c] ? (!gaps || $urandom_range(3, 0) != 0) : 1'b1;
                    s_tdata[8*c +: 8] = srcq[c][0].d;
                    s_tlast[c] = srcq[c][0].l;
                end else begin
                    mid[c] = 0;
                    s_tvalid[c] = 1'b0;
                    s_tdata[8*c +: 8] = 8'($urandom);
                    s_tlast[c] = 1'($urandom);
                end
            end
            m_tready = rdy_rand ? ($urandom_range(9, 0) < 6) : 1'b1;
        end
    end

    // Source driver for the ID-disabled instance: channel 3 only, back to back.
    initial begin
        bit hs;
        z_tvalid = '0; z_tdata = '0; z_tlast = '0; zm_tready = 1'b1;
        forever begin
            @(negedge aclk);
            hs = z_tvalid[3] && z_tready[3];
            @(posedge aclk);
            #1;
            if (hs && zq.size() > 0) void'(zq.pop_front());
            if (zq.size() > 0) begin
                z_tvalid[3] = 1'b1; z_tdata[31:24] = zq[0].d; z_tlast[3] = zq[0].l;
            end else begin
                z_tvalid[3] = 1'b0;
            end
        end
    end

    // Compare process for the ID-enabled instance.
    initial begin
        logic pv, pr, pl;
        logic [7:0] pd;
        logic [NCH-1:0] mask;
        obeat_t e;
        pv = 0; pr = 0; pl = 0; pd = '0;
        forever begin
            @(negedge aclk);
            if (!mon_en || !aresetn) begin
                pv = 0;
                continue;
            end
            if (pv && !pr) begin
                chk("stall_hold_valid", m_tvalid, 1);
                chk("stall_hold_data_last", {m_tdata, m_tlast}, {pd, pl});
            end
            mask = '0;
            if (ordq.size() > 0) mask[ordq[0]] = 1'b1;
            chk("ready_only_granted", s_tready & ~mask, 0);
            if (ordq.size() > 0 && s_tvalid[ordq[0]] && s_tready[ordq[0]] && s_tlast[ordq[0]])
                void'(ordq.pop_front());
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_tdata, m_tlast);
                end else begin
                    e = expq.pop_front();
                    chk("m_tdata", m_tdata, e.d);
                    chk("m_tlast", m_tlast, e.l);
                    if (!e.l) chk("grant_in_packet", grant, e.ch);
                    beat_log.push_back(m_tdata);
                    last_log.push_back(m_tlast);
                    if (e.id) id_log.push_back(m_tdata);
                end
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
        end
    end

    // Compare process for the ID-disabled instance.
    initial begin
        int gap;
        sbeat_t e;
        gap = -1;
        zbeats = 0;
        forever begin
            @(negedge aclk);
            if (!mon0_en || !aresetn) begin
                gap = -1;
                continue;
            end
            if (zm_tvalid && gap >= 0) begin
                chk("z_idle_gap_cycles", gap, 1);
                gap = -1;
            end else if (!zm_tvalid && gap >= 0) begin
                gap++;
            end
            if (zm_tvalid && zm_tready) begin
                zbeats++;
                if (expq0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL z_unexpected_beat: got data 0x%0h, expected no beat", zm_tdata);
                end else begin
                    e = expq0.pop_front();
                    chk("z_m_tdata", zm_tdata, e.d);
                    chk("z_m_tlast", zm_tlast, e.l);
                    if (!e.l) chk("z_grant", z_grant, 3);
                    if (e.l) gap = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        sbeat_t s;
        mlast = NCH - 1;

        // Reset values.
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 3);
        chk("rst_z_grant", z_grant, 3);
        aresetn = 1'b1;
        mon_en = 1;
        @(negedge aclk);
        #1;

        // ch2 sends 11,22,33.
        beat_log.delete(); last_log.delete();
        pkt = '{8'h11, 8'h22, 8'h33};
        add_packet(2);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge aclk);
            n++;
            if (s_tvalid[2] && s_tready[2] && s_tlast[2]) seen = 1;
        end
        chk("t1_tlast_handshake_seen", seen, 1);
        chk("t1_busy_at_tlast", busy, 1);
        @(negedge aclk);
        chk("t1_busy_after_tlast", busy, 0);
        wait_drain("t1", 100);
        chk("t1_beat_count", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            chk("t1_byte0", beat_log[0], 8'h02);
            chk("t1_byte1", beat_log[1], 8'h11);
            chk("t1_byte2", beat_log[2], 8'h22);
            chk("t1_byte3", beat_log[3], 8'h33);
            chk("t1_lasts", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0001);
        end
        chk("t1_grant", grant, 2);

        // ch1 mid-packet, ch0 arrives and must wait.
        id_log.delete();
        pkt.delete();
        repeat (5) pkt.push_back(8'($urandom));
        add_packet(1);
        wait_consumed(1, consumed[1] + 2, "t3_ch1_progress");
        pkt.delete();
        repeat (3) pkt.push_back(8'($urandom));
        add_packet(0);
        @(negedge aclk);
        chk("t3_ch0_held_off", s_tready[0], 0);
        wait_drain("t3", 200);
        chk("t3_id_count", id_log.size(), 2);
        if (id_log.size() == 2) begin
            chk("t3_first_id", id_log[0], 8'h01);
            chk("t3_next_id", id_log[1], 8'h00);
        end

        // Random traffic with backpressure and source gaps.
        rdy_rand = 1;
        gaps = 1;
        repeat (4) begin
            for (int c = 0; c < NCH; c++) cnt[c] = $urandom_range(4, 0);
            rr_load(0);
            wait_drain("random", 3000);
        end
        rdy_rand = 0;
        gaps = 0;
        repeat (2) @(negedge aclk);
        #1;

        // ID-disabled instance: ch3 back-to-back packets of 2,3,1 bytes.
        mon0_en = 1;
        foreach (cnt[k]) cnt[k] = 0;
        for (int p = 0; p < 3; p++) begin
            n = (p == 0) ? 2 : (p == 1) ? 3 : 1;
            for (int k = 0; k < n; k++) begin
                s.d = 8'($urandom); s.l = (k == n - 1);
                expq0.push_back(s);
                zq.push_back(s);
            end
        end
        n = 0;
        while (expq0.size() > 0 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk("z_drained", expq0.size(), 0);
        chk("z_beat_count", zbeats, 6);
        mon0_en = 0;
        @(negedge aclk);
        #1;

        // Reset during byte 3 of a ch2 packet.
        pkt.delete();
        repeat (6) pkt.push_back(8'($urandom));
        add_packet(2);
        wait_consumed(2, consumed[2] + 2, "t6_progress");
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        mon_en = 0;
        #1;
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_m_tdata", m_tdata, 0);
        chk("t6_m_tlast", m_tlast, 0);
        chk("t6_s_tready", s_tready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 3);
        expq.delete();
        ordq.delete();
        for (int c = 0; c < NCH; c++) srcq[c].delete();
        mlast = NCH - 1;
        repeat (2) @(negedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en = 1;
        @(negedge aclk);
        #1;

        // All four channels valid, two 2-byte packets each.
        id_log.delete();
        for (int c = 0; c < NCH; c++) cnt[c] = 2;
        rr_load(2);
        wait_drain("t2", 400);
        chk("t2_id_count", id_log.size(), 8);
        if (id_log.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("t2_id_order", id_log[k], k % 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
